// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEF_TICK_DIV = 100000;
    localparam int unsigned DEF_CNT_W    = 3;
    localparam int unsigned DEF_THRESH   = 7;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // True when the integrator threshold is reachable with a cnt_w-bit counter.
    function automatic bit thresh_fits(input int unsigned cnt_w, input int unsigned thresh);
        return (thresh >= 1) && (cnt_w >= 1) && (cnt_w < 32) &&
               (64'(thresh) <= ((64'd1 << cnt_w) - 64'd1));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, saturating integrator with
// hysteresis, registered level and rise/fall strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned THRESH = DEF_THRESH
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

    logic [1:0]       sync;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_nxt;

    assign s = sync[1];

    // Integrator steps only on ticks; out follows the saturation endpoints.
    always_comb begin
        cnt_nxt = cnt;
        out_nxt = out;
        if (tick) begin
            if (s && (cnt < TH)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else if (!s && (cnt != '0)) begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
        if (cnt_nxt == TH) begin
            out_nxt = 1'b1;
        end else if (cnt_nxt == '0) begin
            out_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], in};
            cnt  <= cnt_nxt;
            out  <= out_nxt;
            rise <= out_nxt & ~out;
            fall <= ~out_nxt & out;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one prescaled sample tick.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned THRESH   = DEF_THRESH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned      PRE_W   = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    if (!thresh_fits(CNT_W, THRESH) || (CHANNELS < 1) || (TICK_DIV < 1)) begin : g_bad_params
        $fatal(1, "debounce_bank: THRESH must lie in 1..2^CNT_W-1, CHANNELS and TICK_DIV >= 1");
    end

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;

    always_comb begin
        pre_nxt = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
    end

    // tick is registered from the next prescaler value so it mirrors pre == PRE_MAX
    // while still clearing under reset (and for TICK_DIV=1 stays high after the first edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= pre_nxt;
            tick <= (pre_nxt == PRE_MAX);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .in   (in[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and randomized bench for debounce_bank against a cycle-level reference model.
module tb_debounce_bank;

    localparam int NCH = 4;
    localparam int TD  = 4;
    localparam int TH  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] in_r;
    logic [NCH-1:0] out, rise, fall;
    logic           tick;

    logic           rst1;
    logic [NCH-1:0] in1;
    logic [NCH-1:0] out1, rise1, fall1;
    logic           tick1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int k;
    int mcnt [NCH];
    bit mlvl [NCH];
    bit mr   [NCH];
    bit mf   [NCH];
    bit d1   [NCH];
    bit d2   [NCH];
    bit mtick;

    int rise_seen [NCH];
    int fall_seen [NCH];

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(NCH), .TICK_DIV(TD), .CNT_W(3), .THRESH(TH)) dut (
        .clk (clk), .rst (rst), .in (in_r),
        .out (out), .rise (rise), .fall (fall), .tick (tick)
    );

    debounce_bank #(.CHANNELS(NCH), .TICK_DIV(1), .CNT_W(3), .THRESH(TH)) dut1 (
        .clk (clk), .rst (rst1), .in (in1),
        .out (out1), .rise (rise1), .fall (fall1), .tick (tick1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        k     = 0;
        mtick = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mcnt[i] = 0; mlvl[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0;
            d1[i] = 1'b0; d2[i] = 1'b0;
        end
    endtask

    // Edge k after release consumes a tick when k is a multiple of TD (the
    // first visible tick follows the TD-1'th edge, so edge 1 never samples).
    task automatic model_edge();
        bit tk, prev;
        if (rst) begin
            model_reset();
        end else begin
            k++;
            tk = (k >= 2) && (k % TD == 0);
            for (int i = 0; i < NCH; i++) begin
                prev = mlvl[i];
                if (tk) begin
                    if (d2[i]) mcnt[i] = (mcnt[i] + 1 > TH) ? TH : mcnt[i] + 1;
                    else       mcnt[i] = (mcnt[i] - 1 < 0)  ? 0  : mcnt[i] - 1;
                end
                if (mcnt[i] == TH)     mlvl[i] = 1'b1;
                else if (mcnt[i] == 0) mlvl[i] = 1'b0;
                mr[i] = mlvl[i] && !prev;
                mf[i] = !mlvl[i] && prev;
                d2[i] = d1[i];
                d1[i] = in_r[i];
            end
            mtick = ((k + 1) % TD) == 0;
        end
    endtask

    task automatic cyc();
        logic [NCH-1:0] eo, er, ef;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) begin
            eo[i] = mlvl[i]; er[i] = mr[i]; ef[i] = mf[i];
            rise_seen[i] += int'(rise[i]);
            fall_seen[i] += int'(fall[i]);
        end
        check("out",  32'(out),  32'(eo));
        check("rise", 32'(rise), 32'(er));
        check("fall", 32'(fall), 32'(ef));
        check("tick", 32'(tick), 32'(mtick));
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NCH; i++) begin
            rise_seen[i] = 0; fall_seen[i] = 0;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cyc();
    endtask

    initial begin
        logic [2:0] saved;
        int         n;
        bit         hit;

        rst  = 1'b1;
        rst1 = 1'b1;
        in_r = 4'hF;
        in1  = 4'h0;
        model_reset();
        clear_seen();

        // Reset with inputs held high
        run(3);
        #3 rst = 1'b0;
        clear_seen();
        run(14);
        check("reset_out_by_14", 32'(out), 32'hF);
        run(2);
        for (int i = 0; i < NCH; i++) check("reset_rise_once", 32'(rise_seen[i]), 32'd1);

        // Glitch rejection on channel 0
        in_r[0] = 1'b0;
        run(16);
        clear_seen();
        in_r[0] = 1'b1;
        run(8);
        in_r[0] = 1'b0;
        run(16);
        check("glitch_out0", 32'(out[0]), 32'd0);
        check("glitch_rise0", 32'(rise_seen[0]), 32'd0);
        check("glitch_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'(mcnt[0]));

        // Hysteresis on channel 1
        in_r[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            check("hyst_cnt1", 32'(dut.g_ch[1].u_ch.cnt), 32'(mcnt[1]));
        end
        in_r[1] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cyc();
            check("hyst_cnt1", 32'(dut.g_ch[1].u_ch.cnt), 32'(mcnt[1]));
        end
        check("hyst_out1", 32'(out[1]), 32'd1);
        check("hyst_fall1", 32'(fall_seen[1]), 32'd0);

        // Fall on channel 2
        clear_seen();
        in_r[2] = 1'b0;
        run(16);
        check("fall_out2", 32'(out[2]), 32'd0);
        check("fall_fall2", 32'(fall_seen[2]), 32'd1);
        check("fall_rise2", 32'(rise_seen[2]), 32'd0);

        // Isolation: channel 3 toggles every clock
        clear_seen();
        saved = 3'b010;
        for (int c = 0; c < 40; c++) begin
            in_r[3] = ~in_r[3];
            cyc();
            check("iso_out", 32'(out[2:0]), 32'(saved));
        end
        for (int i = 0; i < 3; i++) begin
            check("iso_rise", 32'(rise_seen[i]), 32'd0);
            check("iso_fall", 32'(fall_seen[i]), 32'd0);
        end

        // Randomized run-length stimulus
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 9) == 0) in_r[i] = ~in_r[i];
            end
            cyc();
        end

        // Asynchronous reset while channel 0 sits at cnt=2 with out=1
        in_r = 4'hF;
        run(20);
        in_r[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            cyc();
            hit = (mcnt[0] == 2);
        end
        check("arst_reach_cnt2", 32'(hit), 32'd1);
        check("arst_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd2);
        check("arst_out0_pre", 32'(out[0]), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_rise", 32'(rise), 32'd0);
        check("arst_fall", 32'(fall), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        run(2);
        #3 rst = 1'b0;
        clear_seen();
        run(20);
        for (int i = 0; i < NCH; i++) check("arst_no_fall", 32'(fall_seen[i]), 32'd0);

        // TICK_DIV=1 instance: rise 5 clocks after the input change
        #3 rst1 = 1'b0;
        cyc();
        check("td1_tick", 32'(tick1), 32'd1);
        in1 = 4'h1;
        n   = 0;
        hit = 1'b0;
        for (int c = 0; c < 12 && !hit; c++) begin
            cyc();
            n++;
            hit = rise1[0];
        end
        check("td1_rise_latency", 32'(n), 32'd5);
        check("td1_out_at_rise", 32'(out1[0]), 32'd1);
        cyc();
        check("td1_rise_width", 32'(rise1[0]), 32'd0);
        check("td1_out_hold", 32'(out1), 32'h1);
        check("td1_fall", 32'(fall1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
